// File: rtl/rv_pkg.sv
// Shared definitions for the rv32i fetch front end.
// Holds the default address width, the reset and trap vectors, the sequential
// increment and history depth, and the next-PC select enum. The enum drives
// the pc_unit select mux and is also handy in debug traces.
package rv_pkg;

   localparam int          XLEN       = 32;
   localparam logic [31:0] RESET_VEC  = 32'h0000_0000;
   localparam logic [31:0] TRAP_VEC   = 32'h0000_0100;
   localparam int          PC_INC     = 4;
   localparam int          HIST_DEPTH = 2;

   // Source of the next PC, in no particular priority order
   typedef enum logic [2:0] {
      NPC_SEQ,
      NPC_HOLD,
      NPC_BR,
      NPC_JAL,
      NPC_JALR,
      NPC_TRAP
   } npc_sel_e;

endpackage

// File: rtl/pc_history.sv
// Shift register of recently fetched PCs, each entry with its own valid bit.
// Ports:
//   clk, rst    clock and synchronous active-high reset
//   push        shift pc into entry 0; older entries move down one slot
//   flush       clear every valid bit; the stored PC values are kept
//   pc          PC to record on push
//   hist_pc     flattened entries, entry 0 (newest) in [XLEN-1:0]
//   hist_valid  per-entry valid, bit k belongs to entry k
module pc_history #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    push,
   input  logic                    flush,
   input  logic [XLEN-1:0]         pc,
   output logic [DEPTH*XLEN-1:0]   hist_pc,
   output logic [DEPTH-1:0]        hist_valid
);

   logic [XLEN-1:0] entry [DEPTH];
   logic [DEPTH-1:0] valid;

   // Flush wins over push so that a redirect never records a squashed fetch.
   // Otherwise a push shifts PCs and valid bits down together, a 1 entering at 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < DEPTH; k++) begin
            entry[k] <= '0;
         end
         valid <= '0;
      end else if (flush) begin
         valid <= '0;
      end else if (push) begin
         entry[0] <= pc;
         for (int k = 1; k < DEPTH; k++) begin
            entry[k] <= entry[k-1];
         end
         valid <= {valid[DEPTH-2:0], 1'b1};
      end
   end

   // Flatten the entry array onto the output bus
   for (genvar g = 0; g < DEPTH; g++) begin : g_flat
      assign hist_pc[g*XLEN +: XLEN] = entry[g];
   end

   assign hist_valid = valid;

endmodule

// File: rtl/pc_unit.sv
// Fetch program counter for the rv32i core.
// Chooses the next PC by priority (trap, JALR, JAL, taken branch, sequential
// or hold), runs the valid/ready request to instruction memory, flags
// misaligned redirect targets by trapping, and keeps a short history of
// fetched PCs.
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   stall_i                  hold the PC and withdraw the fetch request
//   trap_i, jalr_i, jump_i   redirect requests, in falling priority
//   branch_i, branch_taken_i resolved branch and its outcome
//   target_i                 redirect target for JALR / JAL / branch
//   fetch_ready_i            instruction memory accepts the request
//   fetch_valid_o, fetch_pc_o  fetch request and its address (the PC)
//   redirect_o               redirect happening this cycle, flush upstream
//   misalign_o               one-cycle pulse after a misaligned target
//   misalign_addr_o          last misaligned target, held until the next one
//   hist_pc_o, hist_valid_o  fetched-PC history, entry 0 newest
module pc_unit #(
   parameter int               XLEN       = rv_pkg::XLEN,
   parameter logic [XLEN-1:0]  RESET_VEC  = rv_pkg::RESET_VEC,
   parameter logic [XLEN-1:0]  TRAP_VEC   = rv_pkg::TRAP_VEC,
   parameter int               PC_INC     = rv_pkg::PC_INC,
   parameter int               HIST_DEPTH = rv_pkg::HIST_DEPTH
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       stall_i,
   input  logic                       trap_i,
   input  logic                       jalr_i,
   input  logic                       jump_i,
   input  logic                       branch_i,
   input  logic                       branch_taken_i,
   input  logic [XLEN-1:0]            target_i,
   input  logic                       fetch_ready_i,
   output logic                       fetch_valid_o,
   output logic [XLEN-1:0]            fetch_pc_o,
   output logic                       redirect_o,
   output logic                       misalign_o,
   output logic [XLEN-1:0]            misalign_addr_o,
   output logic [HIST_DEPTH*XLEN-1:0] hist_pc_o,
   output logic [HIST_DEPTH-1:0]      hist_valid_o
);

   import rv_pkg::*;

   logic            rst_d;
   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] next_pc;
   logic [XLEN-1:0] eff_target;
   logic            fire;
   logic            redirect;
   logic            misaligned;
   npc_sel_e        sel;

   // One-cycle delayed reset keeps the request low for the first cycle out of reset
   always_ff @(posedge clk) begin
      rst_d <= rst;
   end

   assign fetch_valid_o = !rst && !rst_d && !stall_i;
   assign fire          = fetch_valid_o && fetch_ready_i;
   assign fetch_pc_o    = pc;

   // Priority select of the next-PC source. JALR clears the target LSB before
   // the alignment check, so only bit 1 can make a JALR target misaligned.
   always_comb begin
      sel        = NPC_HOLD;
      eff_target = target_i;
      if (trap_i) begin
         sel = NPC_TRAP;
      end else if (jalr_i) begin
         sel        = NPC_JALR;
         eff_target = {target_i[XLEN-1:1], 1'b0};
      end else if (jump_i) begin
         sel = NPC_JAL;
      end else if (branch_i && branch_taken_i) begin
         sel = NPC_BR;
      end else if (fire) begin
         sel = NPC_SEQ;
      end
   end

   // Traps are never alignment-checked; the other redirects fall to TRAP_VEC
   // when their target is not word aligned.
   always_comb begin
      redirect   = 1'b0;
      misaligned = 1'b0;
      next_pc    = pc;
      case (sel)
         NPC_TRAP: begin
            redirect = 1'b1;
            next_pc  = TRAP_VEC;
         end
         NPC_JALR, NPC_JAL, NPC_BR: begin
            redirect   = 1'b1;
            misaligned = (eff_target[1:0] != 2'b00);
            next_pc    = misaligned ? TRAP_VEC : eff_target;
         end
         NPC_SEQ:  next_pc = pc + XLEN'(PC_INC);
         NPC_HOLD: next_pc = pc;
         default:  next_pc = pc;
      endcase
      if (rst) begin
         redirect   = 1'b0;
         misaligned = 1'b0;
      end
   end

   assign redirect_o = redirect;

   // PC register plus the misalignment pulse and the captured offending address
   always_ff @(posedge clk) begin
      if (rst) begin
         pc              <= RESET_VEC;
         misalign_o      <= 1'b0;
         misalign_addr_o <= '0;
      end else begin
         pc         <= next_pc;
         misalign_o <= misaligned;
         if (misaligned) begin
            misalign_addr_o <= eff_target;
         end
      end
   end

   // A fetch accepted in a redirect cycle is squashed, so it never enters history
   pc_history #(
      .XLEN  (XLEN),
      .DEPTH (HIST_DEPTH)
   ) u_history (
      .clk        (clk),
      .rst        (rst),
      .push       (fire && !redirect),
      .flush      (redirect),
      .pc         (pc),
      .hist_pc    (hist_pc_o),
      .hist_valid (hist_valid_o)
   );

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit. Stimulus pushes expected values, tagged with
// the cycle they belong to, into a queue; a monitor on the falling edge pops
// every entry due in the current cycle and compares it with the DUT.
module tb_pc_unit;

   localparam int XLEN  = 32;
   localparam int DEPTH = 2;

   localparam int K_PC    = 0;
   localparam int K_VALID = 1;
   localparam int K_REDIR = 2;
   localparam int K_MIS   = 3;
   localparam int K_MADDR = 4;
   localparam int K_H0    = 5;
   localparam int K_H1    = 6;
   localparam int K_HV    = 7;

   logic                    clk;
   logic                    rst;
   logic                    stall_i;
   logic                    trap_i;
   logic                    jalr_i;
   logic                    jump_i;
   logic                    branch_i;
   logic                    branch_taken_i;
   logic [XLEN-1:0]         target_i;
   logic                    fetch_ready_i;
   logic                    fetch_valid_o;
   logic [XLEN-1:0]         fetch_pc_o;
   logic                    redirect_o;
   logic                    misalign_o;
   logic [XLEN-1:0]         misalign_addr_o;
   logic [DEPTH*XLEN-1:0]   hist_pc_o;
   logic [DEPTH-1:0]        hist_valid_o;

   typedef struct {
      int          cyc;
      int          kind;
      logic [31:0] val;
      string       name;
   } exp_t;

   exp_t q[$];
   int   cyc;
   int   checks;
   int   errors;
   int   leftover;

   pc_unit dut (
      .clk             (clk),
      .rst             (rst),
      .stall_i         (stall_i),
      .trap_i          (trap_i),
      .jalr_i          (jalr_i),
      .jump_i          (jump_i),
      .branch_i        (branch_i),
      .branch_taken_i  (branch_taken_i),
      .target_i        (target_i),
      .fetch_ready_i   (fetch_ready_i),
      .fetch_valid_o   (fetch_valid_o),
      .fetch_pc_o      (fetch_pc_o),
      .redirect_o      (redirect_o),
      .misalign_o      (misalign_o),
      .misalign_addr_o (misalign_addr_o),
      .hist_pc_o       (hist_pc_o),
      .hist_valid_o    (hist_valid_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Cycle counter, advanced on every rising edge
   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: compare every expectation due in this cycle at the falling edge
   always @(negedge clk) begin
      logic [31:0] act;
      while (q.size() > 0 && q[0].cyc <= cyc) begin
         case (q[0].kind)
            K_PC:    act = fetch_pc_o;
            K_VALID: act = {31'b0, fetch_valid_o};
            K_REDIR: act = {31'b0, redirect_o};
            K_MIS:   act = {31'b0, misalign_o};
            K_MADDR: act = misalign_addr_o;
            K_H0:    act = hist_pc_o[XLEN-1:0];
            K_H1:    act = hist_pc_o[2*XLEN-1:XLEN];
            default: act = {30'b0, hist_valid_o};
         endcase
         checks++;
         if (act !== q[0].val) begin
            errors++;
            $display("[TB] FAIL %s (cycle %0d): got 0x%08h, expected 0x%08h",
                     q[0].name, cyc, act, q[0].val);
         end
         void'(q.pop_front());
      end
   end

   // Record an expected value for the current cycle
   task automatic checkOutput(input int kind, input logic [31:0] val, input string name);
      exp_t e;
      e.cyc  = cyc;
      e.kind = kind;
      e.val  = val;
      e.name = name;
      q.push_back(e);
   endtask

   // Advance one clock, then drive the given inputs 1 ns after the rising edge
   task automatic applyStimulus(input logic r, input logic st, input logic rdy,
                                input logic tr, input logic jr, input logic jp,
                                input logic br, input logic tk, input logic [31:0] tgt);
      @(posedge clk);
      #1;
      rst            = r;
      stall_i        = st;
      fetch_ready_i  = rdy;
      trap_i         = tr;
      jalr_i         = jr;
      jump_i         = jp;
      branch_i       = br;
      branch_taken_i = tk;
      target_i       = tgt;
   endtask

   // One plain cycle with the memory ready and no redirect
   task automatic idleFetch();
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
   endtask

   // Main sequence: drive each scenario from the specification and queue its expectations
   initial begin
      checks   = 0;
      errors   = 0;
      leftover = 0;
      rst = 1'b1; stall_i = 1'b0; fetch_ready_i = 1'b0; trap_i = 1'b0;
      jalr_i = 1'b0; jump_i = 1'b0; branch_i = 1'b0; branch_taken_i = 1'b0;
      target_i = '0;

      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      checkOutput(K_PC, 32'h0, "reset_pc");
      checkOutput(K_VALID, 32'h0, "reset_valid");
      checkOutput(K_HV, 32'h0, "reset_hist_valid");
      checkOutput(K_MIS, 32'h0, "reset_misalign");
      checkOutput(K_MADDR, 32'h0, "reset_misalign_addr");

      idleFetch();
      checkOutput(K_VALID, 32'h0, "first_cycle_valid");
      checkOutput(K_PC, 32'h0, "first_cycle_pc");
      idleFetch();
      checkOutput(K_VALID, 32'h1, "seq_valid");
      checkOutput(K_PC, 32'h0, "seq_pc0");
      idleFetch();
      checkOutput(K_PC, 32'h4, "seq_pc4");
      checkOutput(K_H0, 32'h0, "seq_h0_after_0");

      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      for (int i = 0; i < 3; i++) begin
         checkOutput(K_PC, 32'h8, "ready_low_pc");
         checkOutput(K_VALID, 32'h1, "ready_low_valid");
         checkOutput(K_H0, 32'h4, "ready_low_h0");
         checkOutput(K_HV, 32'h3, "ready_low_hv");
         if (i < 2) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      end
      idleFetch();
      idleFetch();
      checkOutput(K_PC, 32'hC, "after_ready_pc");
      checkOutput(K_H0, 32'h8, "after_ready_h0");
      checkOutput(K_H1, 32'h4, "after_ready_h1");

      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h41);
      checkOutput(K_PC, 32'h10, "pc_10");
      checkOutput(K_H0, 32'hC, "hist_h0_C");
      checkOutput(K_H1, 32'h8, "hist_h1_8");
      checkOutput(K_HV, 32'h3, "hist_hv_full");
      checkOutput(K_REDIR, 32'h1, "trap_redirect");

      idleFetch();
      checkOutput(K_PC, 32'h100, "trap_pc");
      checkOutput(K_HV, 32'h0, "trap_hist_flush");
      checkOutput(K_H0, 32'hC, "trap_hist_pc_kept");
      checkOutput(K_MIS, 32'h0, "trap_no_misalign");
      checkOutput(K_REDIR, 32'h0, "no_redirect_idle");

      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h41);
      checkOutput(K_REDIR, 32'h1, "jalr_redirect");
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h42);
      checkOutput(K_PC, 32'h40, "jalr_pc");
      checkOutput(K_MIS, 32'h0, "jalr_no_misalign");
      checkOutput(K_REDIR, 32'h1, "jal_mis_redirect");
      idleFetch();
      checkOutput(K_PC, 32'h100, "jal_mis_pc");
      checkOutput(K_MIS, 32'h1, "jal_mis_pulse");
      checkOutput(K_MADDR, 32'h42, "jal_mis_addr");

      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h200);
      checkOutput(K_MIS, 32'h0, "mis_pulse_end");
      checkOutput(K_MADDR, 32'h42, "mis_addr_held");
      checkOutput(K_PC, 32'h104, "pc_104");
      checkOutput(K_H0, 32'h100, "h0_100");
      checkOutput(K_HV, 32'h1, "hv_one");
      checkOutput(K_VALID, 32'h0, "stall_valid");
      checkOutput(K_REDIR, 32'h1, "stall_branch_redirect");
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      checkOutput(K_PC, 32'h200, "stall_branch_pc");
      checkOutput(K_VALID, 32'h0, "stall_hold_valid");
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h300);
      checkOutput(K_PC, 32'h200, "stall_hold_pc");
      checkOutput(K_REDIR, 32'h0, "branch_not_taken_redirect");

      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFC);
      checkOutput(K_PC, 32'h204, "not_taken_pc");
      idleFetch();
      checkOutput(K_PC, 32'hFFFF_FFFC, "top_pc");
      idleFetch();
      checkOutput(K_PC, 32'h0, "wrap_pc");
      checkOutput(K_H0, 32'hFFFF_FFFC, "wrap_h0");
      checkOutput(K_HV, 32'h1, "wrap_hv");

      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      checkOutput(K_PC, 32'h4, "stall_before_reset_pc");
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      checkOutput(K_PC, 32'h0, "mid_reset_pc");
      checkOutput(K_HV, 32'h0, "mid_reset_hv");
      checkOutput(K_MADDR, 32'h0, "mid_reset_maddr");
      checkOutput(K_VALID, 32'h0, "mid_reset_first_valid");

      for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clk);
      leftover = q.size();
      while (q.size() > 0) begin
         errors++;
         $display("[TB] FAIL %s: never compared, expected 0x%08h", q[0].name, q[0].val);
         void'(q.pop_front());
      end

      if (leftover != 0) begin
         $display("[TB] FAIL scoreboard drain: got %0d pending, expected 0", leftover);
      end
      if (checks < 12) begin
         errors++;
         $display("[TB] FAIL check count: got %0d, expected at least 12", checks);
      end
      if (errors == 0) begin
         $display("[TB] PASS all %0d checks", checks);
      end else begin
         $display("[TB] FAIL %0d errors in %0d checks", errors, checks);
      end

      $display("[TB] Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Watchdog against a stuck run
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] timeout");
   end

endmodule
